// File: rtl/mcu_bus_pkg.sv
// Shared definitions for peripherals on the CPU_RV32I data bus: access types,
// timer register offsets and bit positions.
package mcu_bus_pkg;

  typedef enum logic [2:0] {
    BUS_B  = 3'b000,
    BUS_H  = 3'b001,
    BUS_W  = 3'b010,
    BUS_BU = 3'b100,
    BUS_HU = 3'b101
  } bus_ctrl_e;

  localparam logic [7:0] TMR_CTRL   = 8'h00;
  localparam logic [7:0] TMR_PSC    = 8'h04;
  localparam logic [7:0] TMR_CNT    = 8'h08;
  localparam logic [7:0] TMR_CMP    = 8'h0C;
  localparam logic [7:0] TMR_STATUS = 8'h10;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;
  localparam int STAT_MATCH       = 0;
  localparam int STAT_OVF         = 1;

endpackage

// File: rtl/bus_byte_lane.sv
// Byte-lane steering for 32-bit bus registers: merges a B/H/W store into an
// existing word and extracts/extends a B/H/W load from a word.
module bus_byte_lane
  import mcu_bus_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  ctrl,
  output logic [31:0] wr_word,
  output logic        wr_valid,
  input  logic [31:0] rd_word,
  output logic [31:0] rd_data
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    logic signed [7:0]  s8;
    logic signed [31:0] s32;
    s8  = b;
    s32 = s8;
    return sgn ? s32 : {24'd0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    logic signed [15:0] s16;
    logic signed [31:0] s32;
    s16 = h;
    s32 = s16;
    return sgn ? s32 : {16'd0, h};
  endfunction

  always_comb begin
    wr_word  = old_word;
    wr_valid = 1'b0;
    case (ctrl)
      BUS_B, BUS_BU: begin
        wr_valid = 1'b1;
        wr_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      BUS_H, BUS_HU: begin
        if (!lane[0]) begin
          wr_valid = 1'b1;
          wr_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        end
      end
      BUS_W: begin
        if (lane == 2'b00) begin
          wr_valid = 1'b1;
          wr_word  = wdata;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_data = 32'd0;
    case (ctrl)
      BUS_B:  rd_data = ext8(rd_word[{lane, 3'b000} +: 8], 1'b1);
      BUS_BU: rd_data = ext8(rd_word[{lane, 3'b000} +: 8], 1'b0);
      BUS_H:  if (!lane[0]) rd_data = ext16(rd_word[{lane[1], 4'b0000} +: 16], 1'b1);
      BUS_HU: if (!lane[0]) rd_data = ext16(rd_word[{lane[1], 4'b0000} +: 16], 1'b0);
      BUS_W:  if (lane == 2'b00) rd_data = rd_word;
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped prescaled up-counter with compare match, optional auto-reload,
// overflow flag and level interrupt on the CPU_RV32I data bus.
module bus_timer
  import mcu_bus_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        ramControl,
  input  logic [31:0]       wData,
  output logic [31:0]       rData,
  output logic              irq
);

  logic [2:0]       ctrl_q,    ctrl_d;
  logic [CNT_W-1:0] psc_q,     psc_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] cmp_q,     cmp_d;
  logic [1:0]       status_q,  status_d;
  logic [CNT_W-1:0] psc_cnt_q, psc_cnt_d;
  logic             irq_q,     irq_d;

  logic [2:0]  idx;
  logic        reg_hit;
  logic [31:0] rd_word, merge_old, wr_word, lane_rd;
  logic        wr_valid, wr_en;
  logic        wr_ctrl, wr_psc, wr_cnt, wr_cmp, wr_status;
  logic        tick, cmp_hit, reload, match_set, ovf_set;
  logic [1:0]  w1c;

  assign idx     = addr[4:2];
  assign reg_hit = (addr[ADDR_W-1:5] == '0) && (idx <= TMR_STATUS[4:2]);

  always_comb begin
    rd_word = 32'd0;
    if (reg_hit) begin
      case (idx)
        TMR_CTRL[4:2]:   rd_word = {29'd0, ctrl_q};
        TMR_PSC[4:2]:    rd_word = psc_q;
        TMR_CNT[4:2]:    rd_word = cnt_q;
        TMR_CMP[4:2]:    rd_word = cmp_q;
        TMR_STATUS[4:2]: rd_word = {30'd0, status_q};
        default:         rd_word = 32'd0;
      endcase
    end
  end

  // STATUS merges against zero so only the lanes actually written act as W1C.
  assign merge_old = (idx == TMR_STATUS[4:2]) ? 32'd0 : rd_word;

  bus_byte_lane u_lane (
    .old_word (merge_old),
    .wdata    (wData),
    .lane     (addr[1:0]),
    .ctrl     (ramControl),
    .wr_word  (wr_word),
    .wr_valid (wr_valid),
    .rd_word  (rd_word),
    .rd_data  (lane_rd)
  );

  assign rData     = sel ? lane_rd : 32'd0;
  assign wr_en     = sel & we & wr_valid & reg_hit;
  assign wr_ctrl   = wr_en & (idx == TMR_CTRL[4:2]);
  assign wr_psc    = wr_en & (idx == TMR_PSC[4:2]);
  assign wr_cnt    = wr_en & (idx == TMR_CNT[4:2]);
  assign wr_cmp    = wr_en & (idx == TMR_CMP[4:2]);
  assign wr_status = wr_en & (idx == TMR_STATUS[4:2]);

  assign tick    = ctrl_q[CTRL_EN] & (psc_cnt_q == psc_q);
  assign cmp_hit = (cnt_q == cmp_q);
  assign reload  = cmp_hit & ctrl_q[CTRL_AUTO_RELOAD];

  always_comb begin
    ctrl_d = wr_ctrl ? wr_word[2:0] : ctrl_q;
    psc_d  = wr_psc  ? wr_word      : psc_q;
    cmp_d  = wr_cmp  ? wr_word      : cmp_q;

    psc_cnt_d = psc_cnt_q;
    if (wr_psc)
      psc_cnt_d = '0;
    else if (ctrl_q[CTRL_EN])
      psc_cnt_d = tick ? '0 : psc_cnt_q + 1'b1;

    // A bus write to CNT swallows that cycle's tick, including its flags.
    cnt_d     = cnt_q;
    match_set = 1'b0;
    ovf_set   = 1'b0;
    if (wr_cnt) begin
      cnt_d = wr_word;
    end else if (tick) begin
      match_set = cmp_hit;
      ovf_set   = !reload && (cnt_q == '1);
      cnt_d     = reload ? '0 : cnt_q + 1'b1;
    end

    w1c = wr_status ? wr_word[1:0] : 2'b00;
    status_d = (status_q & ~w1c);
    status_d[STAT_MATCH] = status_d[STAT_MATCH] | match_set;
    status_d[STAT_OVF]   = status_d[STAT_OVF]   | ovf_set;

    irq_d = ctrl_d[CTRL_IRQ_EN] & (|status_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= 3'd0;
      psc_q     <= '0;
      cnt_q     <= '0;
      cmp_q     <= '1;
      status_q  <= 2'd0;
      psc_cnt_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      psc_q     <= psc_d;
      cnt_q     <= cnt_d;
      cmp_q     <= cmp_d;
      status_q  <= status_d;
      psc_cnt_q <= psc_cnt_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule
